// File: rtl/reg_file_sb.sv
// Register file with two bypassed read ports, one write port, a raw debug tap,
// and per-register pending-write counters for RAW hazard detection.
module reg_file_sb #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int CW   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  input  logic            rs1_used,
  input  logic            rs2_used,
  output logic [XLEN-1:0] rd1_data,
  output logic [XLEN-1:0] rd2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            stall,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  output logic            iss_ready,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  localparam int NREG = 1 << AW;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [XLEN-1:0] regs [NREG];
  logic [CW-1:0]   cnt  [NREG];

  logic wb_we;
  logic iss_acc;
  logic wb_clr;

  assign wb_we     = wb_en && (wb_addr != '0);
  assign iss_ready = !((cnt[iss_rd] == CNT_MAX) && !(wb_en && (wb_addr == iss_rd)));
  assign iss_acc   = iss_valid && iss_ready && (iss_rd != '0);
  assign wb_clr    = wb_we && (cnt[wb_addr] != '0);

  // x0 wins over bypass so a write-back aimed at x0 never leaks onto a read port.
  always_comb begin
    rd1_data = '0;
    if (rs1_addr != '0) begin
      if (wb_en && (wb_addr == rs1_addr)) rd1_data = wb_data;
      else                                rd1_data = regs[rs1_addr];
    end
  end

  always_comb begin
    rd2_data = '0;
    if (rs2_addr != '0) begin
      if (wb_en && (wb_addr == rs2_addr)) rd2_data = wb_data;
      else                                rd2_data = regs[rs2_addr];
    end
  end

  // The last outstanding write is resolved this cycle by the bypass, so it no longer blocks.
  assign rs1_busy = (rs1_addr != '0) && (cnt[rs1_addr] != '0) &&
                    !(wb_en && (wb_addr == rs1_addr) && (cnt[rs1_addr] == CNT_ONE));
  assign rs2_busy = (rs2_addr != '0) && (cnt[rs2_addr] != '0) &&
                    !(wb_en && (wb_addr == rs2_addr) && (cnt[rs2_addr] == CNT_ONE));

  assign stall    = (rs1_used && rs1_busy) || (rs2_used && rs2_busy);
  assign dbg_data = regs[dbg_addr];

  // NOTE: the whole array is reset because the architecture requires every register
  // to read 0 after reset; sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (wb_we && (wb_addr == AW'(r))) regs[r] <= wb_data;
        if ((iss_acc && (iss_rd == AW'(r))) && !(wb_clr && (wb_addr == AW'(r))))
          cnt[r] <= cnt[r] + CNT_ONE;
        else if ((wb_clr && (wb_addr == AW'(r))) && !(iss_acc && (iss_rd == AW'(r))))
          cnt[r] <= cnt[r] - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed table-driven bench for reg_file_sb: data path, bypass, scoreboard and reset.
module tb_reg_file_sb;

  logic        clk;
  logic        reset;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_used, rs2_used;
  logic [31:0] rd1_data, rd2_data;
  logic        rs1_busy, rs2_busy;
  logic        stall;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int checks = 0;
  int errors = 0;

  reg_file_sb #(.XLEN(32), .AW(5), .CW(2)) dut (
    .clk(clk), .reset(reset),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rd1_data(rd1_data), .rd2_data(rd2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .stall(stall),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic        u1, u2, iv;
    logic [4:0]  ird;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  dbg;
    logic [31:0] e_rd1, e_rd2, e_dbg;
    logic        e_b1, e_b2, e_stall, e_rdy;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic u1, input logic u2,
                       input logic iv, input logic [4:0] ird, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] dbg);
    rs1_addr = r1; rs2_addr = r2; rs1_used = u1; rs2_used = u2;
    iss_valid = iv; iss_rd = ird; wb_en = we; wb_addr = wa; wb_data = wd; dbg_addr = dbg;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            rs1 rs2 u1 u2 iv ird we wa  wd            dbg  rd1           rd2           dbg_data      b1 b2 st rdy
    vecs[0]  = '{5'd5, 5'd0, 0, 0, 0, 5'd0, 1, 5'd5,  32'hDEADBEEF, 5'd5,  32'hDEADBEEF, 32'h0,        32'h0,        0, 0, 0, 1};
    vecs[1]  = '{5'd5, 5'd0, 0, 0, 0, 5'd0, 1, 5'd0,  32'h00001234, 5'd5,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 0, 0, 0, 1};
    vecs[2]  = '{5'd0, 5'd7, 0, 0, 0, 5'd0, 1, 5'd7,  32'hA5A5A5A5, 5'd7,  32'h0,        32'hA5A5A5A5, 32'h0,        0, 0, 0, 1};
    vecs[3]  = '{5'd0, 5'd7, 0, 0, 0, 5'd0, 1, 5'd17, 32'h00000002, 5'd7,  32'h0,        32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 0, 1};
    vecs[4]  = '{5'd3, 5'd0, 1, 0, 1, 5'd3, 0, 5'd0,  32'h0,        5'd17, 32'h0,        32'h0,        32'h2,        0, 0, 0, 1};
    vecs[5]  = '{5'd3, 5'd0, 1, 0, 1, 5'd3, 0, 5'd0,  32'h0,        5'd0,  32'h0,        32'h0,        32'h0,        1, 0, 1, 1};
    vecs[6]  = '{5'd3, 5'd0, 1, 0, 1, 5'd3, 0, 5'd0,  32'h0,        5'd0,  32'h0,        32'h0,        32'h0,        1, 0, 1, 1};
    vecs[7]  = '{5'd3, 5'd3, 0, 0, 1, 5'd3, 0, 5'd0,  32'h0,        5'd0,  32'h0,        32'h0,        32'h0,        1, 1, 0, 0};
    vecs[8]  = '{5'd3, 5'd0, 1, 0, 0, 5'd3, 0, 5'd0,  32'h0,        5'd0,  32'h0,        32'h0,        32'h0,        1, 0, 1, 0};
    vecs[9]  = '{5'd3, 5'd0, 1, 0, 0, 5'd3, 1, 5'd3,  32'h00000011, 5'd3,  32'h11,       32'h0,        32'h0,        1, 0, 1, 1};
    vecs[10] = '{5'd3, 5'd0, 1, 0, 0, 5'd3, 1, 5'd3,  32'h00000022, 5'd3,  32'h22,       32'h0,        32'h11,       1, 0, 1, 1};
    vecs[11] = '{5'd3, 5'd0, 1, 0, 0, 5'd3, 1, 5'd3,  32'h00000033, 5'd3,  32'h33,       32'h0,        32'h22,       0, 0, 0, 1};
    vecs[12] = '{5'd3, 5'd0, 1, 0, 0, 5'd3, 0, 5'd0,  32'h0,        5'd3,  32'h33,       32'h0,        32'h33,       0, 0, 0, 1};
    vecs[13] = '{5'd9, 5'd0, 1, 0, 1, 5'd9, 0, 5'd0,  32'h0,        5'd0,  32'h0,        32'h0,        32'h0,        0, 0, 0, 1};
    vecs[14] = '{5'd9, 5'd0, 1, 0, 1, 5'd9, 1, 5'd9,  32'h00000099, 5'd9,  32'h99,       32'h0,        32'h0,        0, 0, 0, 1};
    vecs[15] = '{5'd9, 5'd0, 1, 0, 0, 5'd9, 0, 5'd0,  32'h0,        5'd9,  32'h99,       32'h0,        32'h99,       1, 0, 1, 1};
    vecs[16] = '{5'd9, 5'd0, 1, 0, 0, 5'd9, 1, 5'd9,  32'h00000100, 5'd9,  32'h100,      32'h0,        32'h99,       0, 0, 0, 1};
    vecs[17] = '{5'd9, 5'd0, 1, 0, 0, 5'd9, 1, 5'd9,  32'h00000200, 5'd9,  32'h200,      32'h0,        32'h100,      0, 0, 0, 1};
    vecs[18] = '{5'd9, 5'd0, 1, 0, 1, 5'd9, 0, 5'd0,  32'h0,        5'd9,  32'h200,      32'h0,        32'h200,      0, 0, 0, 1};
    vecs[19] = '{5'd9, 5'd0, 1, 0, 0, 5'd9, 0, 5'd0,  32'h0,        5'd9,  32'h200,      32'h0,        32'h200,      1, 0, 1, 1};
    vecs[20] = '{5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 5'd0,  32'h0,        5'd0,  32'h0,        32'h0,        32'h0,        0, 0, 0, 1};
    vecs[21] = '{5'd0, 5'd0, 1, 1, 0, 5'd0, 0, 5'd0,  32'h0,        5'd0,  32'h0,        32'h0,        32'h0,        0, 0, 0, 1};

    reset = 1'b0;
    drive(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 5'd0, 32'h0, 5'd0);
    next_cycle();
    next_cycle();
    reset = 1'b1;
    #1;
    check("init_ready", {31'h0, iss_ready}, 32'h1);
    check("init_stall", {31'h0, stall}, 32'h0);
    check("init_dbg",   dbg_data, 32'h0);
    next_cycle();

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2, vecs[i].iv, vecs[i].ird,
            vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].dbg);
      #1;
      check($sformatf("v%0d rd1", i),   rd1_data, vecs[i].e_rd1);
      check($sformatf("v%0d rd2", i),   rd2_data, vecs[i].e_rd2);
      check($sformatf("v%0d dbg", i),   dbg_data, vecs[i].e_dbg);
      check($sformatf("v%0d busy1", i), {31'h0, rs1_busy},  {31'h0, vecs[i].e_b1});
      check($sformatf("v%0d busy2", i), {31'h0, rs2_busy},  {31'h0, vecs[i].e_b2});
      check($sformatf("v%0d stall", i), {31'h0, stall},     {31'h0, vecs[i].e_stall});
      check($sformatf("v%0d ready", i), {31'h0, iss_ready}, {31'h0, vecs[i].e_rdy});
      next_cycle();
    end

    // Fill x4 to the maximum count, then issue and write back together at max.
    for (int k = 0; k < 3; k++) begin
      drive(5'd0, 5'd0, 0, 0, 1, 5'd4, 0, 5'd0, 32'h0, 5'd0);
      next_cycle();
    end
    drive(5'd4, 5'd0, 1, 0, 1, 5'd4, 1, 5'd4, 32'h44, 5'd0);
    #1;
    check("max_wb ready", {31'h0, iss_ready}, 32'h1);
    check("max_wb busy",  {31'h0, rs1_busy},  32'h1);
    check("max_wb rd1",   rd1_data, 32'h44);
    next_cycle();
    drive(5'd4, 5'd0, 1, 0, 1, 5'd4, 0, 5'd0, 32'h0, 5'd4);
    #1;
    check("max_hold ready", {31'h0, iss_ready}, 32'h0);
    check("max_hold busy",  {31'h0, rs1_busy},  32'h1);
    check("max_hold dbg",   dbg_data, 32'h44);
    next_cycle();

    // Mid-cycle reset with x4 and x9 still pending and data preloaded.
    drive(5'd4, 5'd9, 1, 1, 0, 5'd4, 0, 5'd0, 32'h0, 5'd5);
    #1;
    check("pre_rst stall", {31'h0, stall}, 32'h1);
    check("pre_rst dbg",   dbg_data, 32'hDEADBEEF);
    #2;
    reset = 1'b0;
    #1;
    check("rst stall", {31'h0, stall},     32'h0);
    check("rst ready", {31'h0, iss_ready}, 32'h1);
    check("rst busy1", {31'h0, rs1_busy},  32'h0);
    check("rst busy2", {31'h0, rs2_busy},  32'h0);
    check("rst rd1",   rd1_data, 32'h0);
    for (int a = 0; a < 32; a++) begin
      dbg_addr = 5'(a);
      #0.1;
      check($sformatf("rst dbg x%0d", a), dbg_data, 32'h0);
    end
    next_cycle();
    reset = 1'b1;
    drive(5'd5, 5'd17, 0, 0, 0, 5'd0, 0, 5'd0, 32'h0, 5'd7);
    next_cycle();
    check("post_rst rd1", rd1_data, 32'h0);
    check("post_rst rd2", rd2_data, 32'h0);
    check("post_rst dbg", dbg_data, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
